// File: rtl/alu_pipe_regfile.sv
// Two-stage decode/execute unit: operands are captured into X and the ALU result is
// written back to the register file and presented in W, with same-cycle forwarding.
module alu_pipe_regfile #(
    parameter int WIDTH      = 4,
    parameter int NREG       = 8,
    parameter int SIGNED_CMP = 0,
    localparam int AW        = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AW-1:0]    in_rs,
    input  logic [AW-1:0]    in_rt,
    input  logic [AW-1:0]    in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_rd,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [2:0] {
        OP_SUB = 3'b000,
        OP_ADD = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_SRA = 3'b100,
        OP_ROL = 3'b101,
        OP_LT  = 3'b110,
        OP_EQ  = 3'b111
    } op_e;

    logic [WIDTH-1:0] r_regs [NREG];

    logic             r_x_valid;
    op_e              r_x_op;
    logic [AW-1:0]    r_x_rd;
    logic [WIDTH-1:0] r_x_a;
    logic [WIDTH-1:0] r_x_b;

    logic             r_out_valid;
    logic [AW-1:0]    r_out_rd;
    logic [WIDTH-1:0] r_out_data;

    logic             w_free;
    logic             w_x_adv;
    logic             w_accept;
    logic             w_lt;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // a producer holding valid keeps its payload stable until that edge.
    assign w_free   = !r_out_valid || out_ready;
    assign w_x_adv  = r_x_valid && w_free;
    assign in_ready = !r_x_valid || w_x_adv;
    assign w_accept = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign out_rd    = r_out_rd;
    assign out_data  = r_out_data;

    assign w_lt = (SIGNED_CMP != 0) ? ($signed(r_x_a) < $signed(r_x_b)) : (r_x_a < r_x_b);

    always_comb begin
        w_alu = '0;
        case (r_x_op)
            OP_SUB:  w_alu = r_x_a - r_x_b;
            OP_ADD:  w_alu = r_x_a + r_x_b;
            OP_OR:   w_alu = r_x_a | r_x_b;
            OP_AND:  w_alu = r_x_a & r_x_b;
            OP_SRA:  w_alu = {r_x_b[WIDTH-1], r_x_b[WIDTH-1:1]};
            OP_ROL:  w_alu = {r_x_a[WIDTH-2:0], r_x_a[WIDTH-1]};
            OP_LT:   w_alu = {{(WIDTH-1){1'b0}}, w_lt};
            OP_EQ:   w_alu = {{(WIDTH-1){1'b0}}, (r_x_a == r_x_b)};
            default: w_alu = '0;
        endcase
    end

    // The instruction leaving X writes the register file at this same edge, so a
    // dependent instruction being accepted now takes the ALU result directly.
    assign w_a = (w_x_adv && (r_x_rd == in_rs)) ? w_alu : r_regs[in_rs];
    assign w_b = (w_x_adv && (r_x_rd == in_rt)) ? w_alu : r_regs[in_rt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_x_adv && (r_x_rd == AW'(i))) begin
                    r_regs[i] <= w_alu;
                end else if (ld_en && (ld_addr == AW'(i))) begin
                    r_regs[i] <= ld_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_valid <= 1'b0;
            r_x_op    <= OP_SUB;
            r_x_rd    <= '0;
            r_x_a     <= '0;
            r_x_b     <= '0;
        end else if (w_accept) begin
            r_x_valid <= 1'b1;
            r_x_op    <= op_e'(in_op);
            r_x_rd    <= in_rd;
            r_x_a     <= w_a;
            r_x_b     <= w_b;
        end else if (w_x_adv) begin
            r_x_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_rd    <= '0;
            r_out_data  <= '0;
        end else if (w_x_adv) begin
            r_out_valid <= 1'b1;
            r_out_rd    <= r_x_rd;
            r_out_data  <= w_alu;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    a_w_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (r_out_valid && !out_ready) |=> (r_out_valid && $stable(r_out_data) && $stable(r_out_rd)));

endmodule

// File: tb/tb_alu_pipe_regfile.sv
// Directed bench for alu_pipe_regfile: one unsigned-compare and one signed-compare
// instance share all inputs; each task checks its own scenario inline.
module tb_alu_pipe_regfile;

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_en = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [3:0] ld_data = '0;
  logic       in_valid = 1'b0;
  logic [2:0] in_op = '0;
  logic [2:0] in_rs = '0;
  logic [2:0] in_rt = '0;
  logic [2:0] in_rd = '0;
  logic       out_ready = 1'b1;

  logic       in_ready0, out_valid0;
  logic [2:0] out_rd0;
  logic [3:0] out_data0;
  logic       in_ready1, out_valid1;
  logic [2:0] out_rd1;
  logic [3:0] out_data1;

  int n_cmp = 0;
  int n_err = 0;

  alu_pipe_regfile #(.WIDTH(4), .NREG(8), .SIGNED_CMP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .in_valid(in_valid), .in_ready(in_ready0), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .out_valid(out_valid0), .out_ready(out_ready),
    .out_rd(out_rd0), .out_data(out_data0)
  );

  alu_pipe_regfile #(.WIDTH(4), .NREG(8), .SIGNED_CMP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .in_valid(in_valid), .in_ready(in_ready1), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .out_valid(out_valid1), .out_ready(out_ready),
    .out_rd(out_rd1), .out_data(out_data1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic load(input logic [2:0] addr, input logic [3:0] data);
    ld_en = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd);
    in_valid = 1'b1;
    in_op = op;
    in_rs = rs;
    in_rt = rt;
    in_rd = rd;
  endtask

  // Issues one instruction into an empty pipeline with out_ready=1 and checks
  // the one-cycle latency, destination and both instances' results.
  task automatic run_op(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic [3:0] exp0, input logic [3:0] exp1,
                        input string name);
    drive(op, rs, rt, rd);
    n_cmp++;
    if (in_ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready: got %b expected 1", name, in_ready0);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid0 !== 1'b0) begin
      n_err++;
      $display("FAIL %s_early: out_valid got %b expected 0", name, out_valid0);
    end
    tick();
    n_cmp++;
    if (out_valid0 !== 1'b1 || out_rd0 !== rd || out_data0 !== exp0) begin
      n_err++;
      $display("FAIL %s: got v=%b rd=%0d data=%h expected v=1 rd=%0d data=%h",
               name, out_valid0, out_rd0, out_data0, rd, exp0);
    end
    n_cmp++;
    if (out_valid1 !== 1'b1 || out_data1 !== exp1) begin
      n_err++;
      $display("FAIL %s_signed: got v=%b data=%h expected v=1 data=%h",
               name, out_valid1, out_data1, exp1);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (out_valid0 !== 1'b0 || out_rd0 !== 3'd0 || out_data0 !== 4'h0 || in_ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL reset: got v=%b rd=%0d data=%h rdy=%b expected 0 0 0 1",
               out_valid0, out_rd0, out_data0, in_ready0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_add();
    load(3'd1, 4'd3);
    load(3'd2, 4'd5);
    run_op(OP_ADD, 3'd1, 3'd2, 3'd3, 4'h8, 4'h8, "add_r3");
    run_op(OP_OR, 3'd3, 3'd3, 3'd3, 4'h8, 4'h8, "readback_r3");
  endtask

  task automatic test_back_to_back();
    load(3'd3, 4'd0);
    drive(OP_ADD, 3'd1, 3'd2, 3'd3);
    tick();
    drive(OP_SUB, 3'd3, 3'd1, 3'd4);
    n_cmp++;
    if (in_ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready: got %b expected 1", in_ready0);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid0 !== 1'b1 || out_rd0 !== 3'd3 || out_data0 !== 4'h8) begin
      n_err++;
      $display("FAIL b2b_first: got v=%b rd=%0d data=%h expected v=1 rd=3 data=8",
               out_valid0, out_rd0, out_data0);
    end
    tick();
    n_cmp++;
    if (out_valid0 !== 1'b1 || out_rd0 !== 3'd4 || out_data0 !== 4'h5) begin
      n_err++;
      $display("FAIL b2b_fwd: got v=%b rd=%0d data=%h expected v=1 rd=4 data=5",
               out_valid0, out_rd0, out_data0);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_q[$];
    logic [3:0] got;
    exp_q = '{4'h6, 4'hA, 4'h8};
    out_ready = 1'b0;
    drive(OP_ADD, 3'd1, 3'd1, 3'd5);
    tick();
    drive(OP_ADD, 3'd2, 3'd2, 3'd6);
    n_cmp++;
    if (in_ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_second_ready: got %b expected 1", in_ready0);
    end
    tick();
    drive(OP_ADD, 3'd1, 3'd2, 3'd7);
    tick();
    tick();
    n_cmp++;
    if (in_ready0 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stall: in_ready got %b expected 0", in_ready0);
    end
    n_cmp++;
    if (out_valid0 !== 1'b1 || out_rd0 !== 3'd5 || out_data0 !== 4'h6) begin
      n_err++;
      $display("FAIL bp_hold: got v=%b rd=%0d data=%h expected v=1 rd=5 data=6",
               out_valid0, out_rd0, out_data0);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready0);
    end
    for (int i = 0; i < 3; i++) begin
      got = out_data0;
      n_cmp++;
      if (out_valid0 !== 1'b1 || got !== exp_q[0]) begin
        n_err++;
        $display("FAIL bp_order%0d: got v=%b data=%h expected v=1 data=%h",
                 i, out_valid0, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
      in_valid = 1'b0;
    end
    n_cmp++;
    if (out_valid0 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: out_valid got %b expected 0", out_valid0);
    end
  endtask

  task automatic test_edge_ops();
    load(3'd0, 4'hF);
    load(3'd1, 4'h1);
    load(3'd2, 4'h0);
    load(3'd3, 4'h8);
    load(3'd4, 4'h9);
    load(3'd5, 4'h3);
    load(3'd6, 4'h5);
    load(3'd7, 4'h7);
    run_op(OP_ADD, 3'd0, 3'd1, 3'd2, 4'h0, 4'h0, "add_wrap");
    run_op(OP_SUB, 3'd2, 3'd1, 3'd2, 4'hF, 4'hF, "sub_wrap");
    run_op(OP_SRA, 3'd0, 3'd3, 3'd3, 4'hC, 4'hC, "sra");
    run_op(OP_ROL, 3'd4, 3'd0, 3'd4, 4'h3, 4'h3, "rol");
    run_op(OP_LT, 3'd5, 3'd6, 3'd5, 4'h1, 4'h1, "lt_3_5");
    run_op(OP_EQ, 3'd7, 3'd7, 3'd0, 4'h1, 4'h1, "eq_7_7");
    load(3'd6, 4'h6);
    run_op(OP_EQ, 3'd7, 3'd6, 3'd1, 4'h0, 4'h0, "eq_7_6");
  endtask

  task automatic test_signed_cmp();
    load(3'd0, 4'hF);
    load(3'd1, 4'h1);
    run_op(OP_LT, 3'd0, 3'd1, 3'd2, 4'h0, 4'h1, "lt_f_1");
  endtask

  task automatic test_reset_inflight();
    load(3'd1, 4'd3);
    load(3'd2, 4'd5);
    out_ready = 1'b0;
    drive(OP_ADD, 3'd1, 3'd2, 3'd6);
    tick();
    drive(OP_ADD, 3'd1, 3'd2, 3'd7);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pre: got v=%b rdy=%b expected v=1 rdy=0", out_valid0, in_ready0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid0 !== 1'b0 || out_data0 !== 4'h0 || out_rd0 !== 3'd0 || in_ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL rst_async: got v=%b rd=%0d data=%h rdy=%b expected 0 0 0 1",
               out_valid0, out_rd0, out_data0, in_ready0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_valid0 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_no_wb: out_valid got %b expected 0", out_valid0);
    end
    for (int r = 0; r < 8; r++) begin
      run_op(OP_OR, 3'(r), 3'(r), 3'(r), 4'h0, 4'h0, $sformatf("rst_r%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_backpressure();
    test_edge_ops();
    test_signed_cmp();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
